// File: rtl/fsbm_sad_core_if.sv
// fsbm_sad_core_if -- pixel-stream and result bundle for the SAD core.
//   master : drives en_init, cur_valid/cur_pix, ref_valid/ref_pix; sees results
//   slave  : the core; consumes the streams, drives busy/done/best_sad/mv_x/mv_y
// Widths derive from the same parameters the core uses, so both ends agree.
interface fsbm_sad_core_if #(
  parameter int WORD_WIDTH = 8,
  parameter int BLK        = 4,
  parameter int SR         = 2
);
  localparam int SAD_W = WORD_WIDTH + $clog2(BLK*BLK);
  localparam int MV_W  = $clog2(SR+1) + 1;

  logic                    en_init;
  logic                    cur_valid;
  logic [WORD_WIDTH-1:0]   cur_pix;
  logic                    ref_valid;
  logic [WORD_WIDTH-1:0]   ref_pix;
  logic                    busy;
  logic                    done;
  logic [SAD_W-1:0]        best_sad;
  logic signed [MV_W-1:0]  mv_x;
  logic signed [MV_W-1:0]  mv_y;

  modport master (
    output en_init, cur_valid, cur_pix, ref_valid, ref_pix,
    input  busy, done, best_sad, mv_x, mv_y
  );
  modport slave (
    input  en_init, cur_valid, cur_pix, ref_valid, ref_pix,
    output busy, done, best_sad, mv_x, mv_y
  );
endinterface

// File: rtl/fsbm_sad_core.sv
// fsbm_sad_core -- full-search block-matching SAD engine.
// Loads one BLK x BLK current block, then accumulates |cur - ref| over a
// stream of (2SR+1)^2 reference candidates (dy outer, dx inner, -SR..+SR)
// and reports the minimum SAD with its motion vector.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : fsbm_sad_core_if.slave (pixel streams in, busy/done/result out)
module fsbm_sad_core #(
  parameter int WORD_WIDTH = 8,
  parameter int BLK        = 4,
  parameter int SR         = 2
) (
  input  logic              clk,
  input  logic              rst,
  fsbm_sad_core_if.slave    bus
);
  localparam int NPIX   = BLK*BLK;
  localparam int NCAND  = (2*SR+1)*(2*SR+1);
  localparam int SAD_W  = WORD_WIDTH + $clog2(NPIX);
  localparam int MV_W   = $clog2(SR+1) + 1;
  localparam int PIX_W  = $clog2(NPIX);
  localparam int CAND_W = $clog2(NCAND);

  localparam logic [PIX_W-1:0]       PIX_LAST  = PIX_W'(NPIX-1);
  localparam logic [CAND_W-1:0]      CAND_LAST = CAND_W'(NCAND-1);
  localparam logic signed [MV_W-1:0] SR_P      = MV_W'(SR);
  localparam logic signed [MV_W-1:0] SR_N      = -SR_P;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_SEARCH = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]              state;
  logic [WORD_WIDTH-1:0]   cur_mem [NPIX];
  logic [PIX_W-1:0]        pix_cnt;
  logic [CAND_W-1:0]       cand_cnt;
  logic [SAD_W-1:0]        acc, best_int;
  logic signed [MV_W-1:0]  dx, dy, best_dx, best_dy;
  logic                    best_vld;
  logic [SAD_W-1:0]        best_sad_r;
  logic signed [MV_W-1:0]  mv_x_r, mv_y_r;

  // Datapath: one absolute difference per accepted reference pixel.
  logic signed [WORD_WIDTH:0] diff, mag;
  logic [WORD_WIDTH-1:0]      absd;
  logic [SAD_W-1:0]           sum;
  logic                       pix_last, cand_last, take_best;

  always_comb begin
    diff      = $signed({1'b0, cur_mem[pix_cnt]}) - $signed({1'b0, bus.ref_pix});
    mag       = diff[WORD_WIDTH] ? -diff : diff;
    absd      = mag[WORD_WIDTH-1:0];
    sum       = acc + {{(SAD_W-WORD_WIDTH){1'b0}}, absd};
    pix_last  = (pix_cnt == PIX_LAST);
    cand_last = (cand_cnt == CAND_LAST);
    // strict < keeps the first minimum in scan order
    take_best = !best_vld || (sum < best_int);
  end

  // Current-block store; only written while loading and not being restarted.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && bus.cur_valid && !bus.en_init)
      cur_mem[pix_cnt] <= bus.cur_pix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pix_cnt    <= '0;
      cand_cnt   <= '0;
      acc        <= '0;
      dx         <= SR_N;
      dy         <= SR_N;
      best_int   <= '0;
      best_dx    <= '0;
      best_dy    <= '0;
      best_vld   <= 1'b0;
      best_sad_r <= '0;
      mv_x_r     <= '0;
      mv_y_r     <= '0;
    end else if (bus.en_init) begin
      // Start or abort from any state. Results are untouched, so an abort
      // leaves the previous match visible; in DONE the done cycle still
      // happens because done is decoded from the current state.
      state    <= S_LOAD;
      pix_cnt  <= '0;
      cand_cnt <= '0;
      acc      <= '0;
      dx       <= SR_N;
      dy       <= SR_N;
      best_vld <= 1'b0;
    end else begin
      case (state)
        S_LOAD: if (bus.cur_valid) begin
          if (pix_cnt == PIX_LAST) begin
            pix_cnt  <= '0;
            cand_cnt <= '0;
            acc      <= '0;
            state    <= S_SEARCH;
          end else begin
            pix_cnt <= pix_cnt + PIX_W'(1);
          end
        end
        S_SEARCH: if (bus.ref_valid) begin
          if (!pix_last) begin
            acc     <= sum;
            pix_cnt <= pix_cnt + PIX_W'(1);
          end else begin
            if (take_best) begin
              best_int <= sum;
              best_dx  <= dx;
              best_dy  <= dy;
              best_vld <= 1'b1;
            end
            acc      <= '0;
            pix_cnt  <= '0;
            cand_cnt <= cand_cnt + CAND_W'(1);
            if (dx == SR_P) begin
              dx <= SR_N;
              dy <= dy + MV_W'(1);
            end else begin
              dx <= dx + MV_W'(1);
            end
            if (cand_last) begin
              // Publish the final best now so the outputs are already
              // valid during the single DONE cycle.
              best_sad_r <= take_best ? sum : best_int;
              mv_x_r     <= take_best ? dx  : best_dx;
              mv_y_r     <= take_best ? dy  : best_dy;
              state      <= S_DONE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = (state == S_LOAD) || (state == S_SEARCH);
  assign bus.done     = (state == S_DONE);
  assign bus.best_sad = best_sad_r;
  assign bus.mv_x     = mv_x_r;
  assign bus.mv_y     = mv_y_r;
endmodule

// File: tb/tb_fsbm_sad_core.sv
// Directed bench for fsbm_sad_core at default parameters (8-bit, 4x4, +/-2).
// Inputs change 1 time unit after a rising edge; outputs are read there too.
module tb_fsbm_sad_core;
  localparam int WW    = 8;
  localparam int BLK   = 4;
  localparam int SR    = 2;
  localparam int NPIX  = BLK*BLK;
  localparam int NCAND = (2*SR+1)*(2*SR+1);
  localparam int NREF  = NCAND*NPIX;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fsbm_sad_core_if #(.WORD_WIDTH(WW), .BLK(BLK), .SR(SR)) bus();
  fsbm_sad_core #(.WORD_WIDTH(WW), .BLK(BLK), .SR(SR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int ncmp = 0;
  int nerr = 0;
  int cyc = 0;
  int done_cnt = 0;
  int cyc0, dc;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scenario pixel tables (candidate index c = (dy+2)*5 + (dx+2)).
  //  2: cur=10i; cand 3 (dx=+1,dy=-2) equals cur, others 255 -> SAD 2880
  //  3: cur=0, ref=255 -> every SAD 4080
  //  4: cur=3i; cand 12 (0,0) and 24 (+2,+2) = cur with pixel 5 +7 -> SAD 7;
  //     others cur+100 -> SAD 1600
  function automatic logic [7:0] cur_px(input int scen, input int i);
    case (scen)
      2:       return 8'(10*i);
      4:       return 8'(3*i);
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] ref_px(input int scen, input int c, input int p);
    case (scen)
      2:       return (c == 3) ? 8'(10*p) : 8'd255;
      4:       return (c == 12 || c == 24) ? 8'(3*p + ((p == 5) ? 7 : 0)) : 8'(3*p + 100);
      default: return 8'd255;
    endcase
  endfunction

  task automatic start();
    bus.en_init = 1'b1;
    step();
    bus.en_init = 1'b0;
  endtask

  // Gap mode: valid drops on ~50% of cycles (never more than 8 in a row);
  // the other stream's valid is held high with junk data to prove it is ignored.
  task automatic feed_cur(input int scen, input bit gaps);
    for (int i = 0; i < NPIX; i++) begin
      int miss = 0;
      forever begin
        bit v;
        v = (!gaps || miss >= 8) ? 1'b1 : 1'($urandom_range(1, 0));
        bus.cur_valid = v;
        bus.cur_pix   = v ? cur_px(scen, i) : 8'($urandom);
        bus.ref_valid = gaps;
        bus.ref_pix   = 8'($urandom);
        step();
        if (v) break;
        miss++;
      end
    end
    bus.cur_valid = 1'b0;
    bus.ref_valid = 1'b0;
  endtask

  task automatic feed_ref(input int scen, input bit gaps, input int from, input int to);
    for (int k = from; k < to; k++) begin
      int miss = 0;
      forever begin
        bit v;
        v = (!gaps || miss >= 8) ? 1'b1 : 1'($urandom_range(1, 0));
        bus.ref_valid = v;
        bus.ref_pix   = v ? ref_px(scen, k / NPIX, k % NPIX) : 8'($urandom);
        bus.cur_valid = gaps;
        bus.cur_pix   = 8'($urandom);
        step();
        if (v) break;
        miss++;
      end
    end
    bus.ref_valid = 1'b0;
    bus.cur_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.en_init = 1'b0;
    bus.cur_valid = 1'b0;
    bus.cur_pix = '0;
    bus.ref_valid = 1'b0;
    bus.ref_pix = '0;
    repeat (3) step();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sad", bus.best_sad, 0);
    chk("rst_mvx", $signed(bus.mv_x), 0);
    chk("rst_mvy", $signed(bus.mv_y), 0);
    rst = 1'b0;
    step();

    // Exact match, no gaps. done sits 416 edges after the edge sampling
    // en_init: the 418th cycle counting the en_init cycle as the first.
    start();
    cyc0 = cyc;
    chk("s2_busy_rise", bus.busy, 1);
    feed_cur(2, 0);
    feed_ref(2, 0, 0, NREF);
    chk("s2_done", bus.done, 1);
    chk("s2_latency", cyc - cyc0, 416);
    chk("s2_busy_fall", bus.busy, 0);
    chk("s2_sad", bus.best_sad, 0);
    chk("s2_mvx", $signed(bus.mv_x), 1);
    chk("s2_mvy", $signed(bus.mv_y), -2);
    step();
    chk("s2_done_pulse", bus.done, 0);
    chk("s2_done_cnt", done_cnt, 1);
    chk("s2_hold_mvx", $signed(bus.mv_x), 1);

    // Maximum SAD everywhere: first candidate wins.
    start();
    feed_cur(3, 0);
    feed_ref(3, 0, 0, NREF);
    chk("s3_done", bus.done, 1);
    chk("s3_sad", bus.best_sad, 4080);
    chk("s3_mvx", $signed(bus.mv_x), -2);
    chk("s3_mvy", $signed(bus.mv_y), -2);
    step();

    // Reset mid-search clears the results; stray ref pulses do nothing.
    start();
    feed_cur(2, 0);
    feed_ref(2, 0, 0, 50);
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    chk("mr_busy", bus.busy, 0);
    chk("mr_done", bus.done, 0);
    chk("mr_sad", bus.best_sad, 0);
    chk("mr_mvx", $signed(bus.mv_x), 0);
    chk("mr_mvy", $signed(bus.mv_y), 0);
    dc = done_cnt;
    for (int i = 0; i < 20; i++) begin
      bus.ref_valid = 1'(i % 2);
      bus.ref_pix = 8'($urandom);
      step();
    end
    bus.ref_valid = 1'b0;
    step();
    chk("mr_idle_busy", bus.busy, 0);
    chk("mr_idle_dcnt", done_cnt, dc);

    // Tie: (0,0) and (+2,+2) both SAD 7; the earlier one is kept.
    start();
    feed_cur(4, 0);
    feed_ref(4, 0, 0, NREF);
    chk("s4_sad", bus.best_sad, 7);
    chk("s4_mvx", $signed(bus.mv_x), 0);
    chk("s4_mvy", $signed(bus.mv_y), 0);
    step();

    // Exact match again with random gaps on both streams.
    start();
    feed_cur(2, 1);
    feed_ref(2, 1, 0, NREF);
    chk("s5_done_lat", bus.done, 1);
    chk("s5_sad", bus.best_sad, 0);
    chk("s5_mvx", $signed(bus.mv_x), 1);
    chk("s5_mvy", $signed(bus.mv_y), -2);
    step();

    // Abort part-way into candidate 12, then a full max-SAD run.
    start();
    feed_cur(4, 0);
    feed_ref(4, 0, 0, 12*NPIX + 5);
    dc = done_cnt;
    start();
    chk("s6_busy", bus.busy, 1);
    chk("s6_hold_sad", bus.best_sad, 0);
    chk("s6_hold_mvx", $signed(bus.mv_x), 1);
    feed_cur(3, 0);
    feed_ref(3, 0, 0, NREF - 1);
    chk("s6_no_done", bus.done, 0);
    chk("s6_no_dcnt", done_cnt, dc);
    chk("s6_hold_mvy", $signed(bus.mv_y), -2);
    feed_ref(3, 0, NREF - 1, NREF);
    chk("s6_done", bus.done, 1);
    chk("s6_sad", bus.best_sad, 4080);
    chk("s6_mvx", $signed(bus.mv_x), -2);
    chk("s6_mvy", $signed(bus.mv_y), -2);
    step();
    chk("s6_dcnt", done_cnt, dc + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/fsbm_sad_core.md
# fsbm_sad_core

Parametrised full-search block-matching engine. Loads one current block of BLK×BLK pixels, then consumes a stream of reference candidate blocks covering every displacement in ±SR. It accumulates the sum of absolute differences (SAD) for each candidate and reports the minimum SAD with its motion vector. It is the compute core of the full-search block-matching design: input sequencing feeds it, and result serialisation consumes its outputs.

## Interface

Parameters:
- WORD_WIDTH, 8: pixel width, unsigned.
- BLK, 4: block dimension; a block holds BLK*BLK pixels, BLK ≥ 2.
- SR, 2: search range; displacements run -SR..+SR in x and y, giving NCAND = (2SR+1)² candidates, SR ≥ 1.
- Derived:
  - SAD_W = WORD_WIDTH + $clog2(BLK*BLK)
  - MV_W = $clog2(SR+1) + 1, two's complement

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: reset, synchronous, active-high.
- en_init, input, 1: start or restart a match; single-cycle pulse.
- cur_valid, input, 1: cur_pix is valid this cycle.
- cur_pix, input, WORD_WIDTH: current-block pixel, raster order.
- ref_valid, input, 1: ref_pix is valid this cycle.
- ref_pix, input, WORD_WIDTH: reference candidate pixel.
- busy, output, 1: high in LOAD and SEARCH.
- done, output, 1: one-cycle pulse; result outputs are updated in the same cycle.
- best_sad, output, SAD_W: minimum SAD.
- mv_x, output, MV_W: signed x displacement of the best candidate.
- mv_y, output, MV_W: signed y displacement of the best candidate.

## Operation

States: IDLE, LOAD, SEARCH, DONE.

- **IDLE**
  - en_init → LOAD; clear all counters and the best-valid flag.
  - cur_valid and ref_valid are ignored.
- **LOAD**
  - Each cycle with cur_valid=1 writes cur_pix into cur_mem[pix_cnt] and increments pix_cnt.
  - The BLK*BLK-th accepted pixel → SEARCH, with pix_cnt=0, cand_cnt=0, acc=0.
  - ref_valid is ignored.
- **SEARCH**
  - Candidates arrive in scan order: dy outer from -SR to +SR, dx inner from -SR to +SR. Each candidate is BLK*BLK pixels in raster order.
  - Each cycle with ref_valid=1: sum = acc + |cur_mem[pix_cnt] − ref_pix|. The difference is computed at WORD_WIDTH+1 bits signed; its magnitude is WORD_WIDTH bits.
  - On pixels that are not the last of a candidate: acc ← sum, pix_cnt++.
  - On the last pixel of a candidate:
    - If the best-valid flag is 0, or sum < best_int (strict), load best_int ← sum and best_dx/best_dy ← current dx/dy, and set the flag.
    - acc ← 0, pix_cnt ← 0, cand_cnt++, and dx/dy advance.
  - On the last pixel of candidate NCAND−1 → DONE.
  - cur_valid is ignored.
- **DONE**
  - Copy best_int, best_dx and best_dy to best_sad, mv_x and mv_y; assert done; → IDLE.
- **Tie-break:** the first minimum in scan order wins.
- **SAD width:** SAD_W never overflows, since the maximum is (2^WORD_WIDTH − 1)·BLK².
- **en_init in LOAD, SEARCH or DONE:** abort → LOAD, with all counters and the flag cleared.
  - The aborted match never produces done.
  - Result outputs keep their previous values.
  - An en_init arriving in the DONE cycle still lets done and the result update occur, then goes to LOAD rather than IDLE.
- **Result hold:** result outputs change only in the DONE cycle and hold until the next DONE.

## Timing

- **Reset:** state=IDLE, busy=0, done=0, best_sad=0, mv_x=0, mv_y=0, counters=0, flag=0.
- **Valid-only handshake:**
  - There is no backpressure; the block accepts one pixel per cycle in LOAD and SEARCH.
  - Gaps (valid low) are allowed anywhere and only stall the counters.
- **busy:**
  - Rises the cycle after the en_init cycle.
  - Falls in the cycle done is high (the DONE state).
- **Latency:** done is high exactly one cycle after the cycle in which the final reference pixel is accepted.
- **Minimum duration:** 1 (en_init) + BLK² + NCAND·BLK² + 1 cycles from en_init to done with no gaps.
  - For the defaults this is 1 + 16 + 400 + 1 = 418 cycles.
- **Simultaneous valids:** cur_valid and ref_valid both high → only the one matching the current state counts.

## Test plan

1. **Reset:** assert rst for 3 cycles mid-SEARCH → next cycle busy=0, done=0, best_sad=0, mv_x=mv_y=0; later ref_valid pulses are ignored.
2. **Exact match (defaults):**
   - Stimulus: cur_pix = 10·i for i = 0..15; every candidate's pixels are 255 except displacement (dx=+1, dy=−2), which equals cur.
   - Required response: best_sad=0, mv_x=+1, mv_y=−2, with done exactly 418 cycles after en_init when there are no gaps.
3. **Maximum SAD:**
   - Stimulus: cur all 0, every ref pixel 255.
   - Required response: best_sad=4080, mv_x=−2, mv_y=−2 (first in scan order).
4. **Tie:**
   - Stimulus: candidates (0,0) and (+2,+2) both give SAD 7; all others give SAD ≥ 100.
   - Required response: mv_x=0, mv_y=0, best_sad=7.
5. **Gaps:**
   - Stimulus: repeat scenario 2 with cur_valid and ref_valid deasserted on a random 50% of cycles, and ref_valid held high during LOAD.
   - Required response: identical result; done one cycle after the last accepted ref pixel.
6. **Abort:**
   - Stimulus: en_init at candidate 12 of a search, then run scenario 3 in full.
   - Required response: no done for the aborted run; the outputs keep the prior values until the single done for the new run, which gives best_sad=4080.
